// File: rtl/dds_mix_dac.sv
// Saturating NCH-channel mixer feeding a 3-wire serial DAC at a fixed sample rate.
// Define DDS_MIX_CLIP_DETECT_EN to add the sticky clip output.
//
// state | meaning
// IDLE  | waiting for the next sample tick
// SHIFT | frame active, 16 bits shifted MSB-first, CLKDIV clk per sclk half-period
// GAP   | cs_n held high for CLKDIV clk before the next frame may start
module dds_mix_dac #(
  parameter int NCH        = 4,
  parameter int CLKDIV     = 4,
  parameter int SAMPLE_DIV = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [16*NCH-1:0] ch_samples,
  input  logic              ovr_clr,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_sdata,
  output logic              busy,
  output logic              overrun
`ifdef DDS_MIX_CLIP_DETECT_EN
  ,
  output logic              clip
`endif
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PH_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLKDIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [CNT_W-1:0]   count;
  logic               tick;
  logic [1:0]         state;
  logic [PH_W-1:0]    phase;
  logic [3:0]         bit_idx;
  logic [15:0]        shreg;
  logic signed [18:0] sum;
  logic [15:0]        sat;
  logic               sat_hit;

  assign tick = (count == CNT_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // 19 bits hold the sum of up to 8 full-scale channels without wrapping
  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = sum + {{3{ch_samples[16*k+15]}}, ch_samples[16*k +: 16]};
    end
  end

  always_comb begin
    sat     = sum[15:0];
    sat_hit = 1'b0;
    if (sum > 19'sd32767) begin
      sat     = 16'h7FFF;
      sat_hit = 1'b1;
    end else if (sum < -19'sd32768) begin
      sat     = 16'h8000;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= '0;
      bit_idx      <= 4'd0;
      shreg        <= 16'h0000;
      sample_out   <= 16'h0000;
      sample_valid <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_sclk     <= 1'b0;
      dac_sdata    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            sample_out   <= sat;
            sample_valid <= 1'b1;
            shreg        <= {~sat[15], sat[14:0]};
            dac_cs_n     <= 1'b0;
            dac_sdata    <= ~sat[15];
            state        <= SHIFT;
            bit_idx      <= 4'd15;
            phase        <= '0;
          end
        end
        SHIFT: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else begin
              dac_sclk <= 1'b0;
              if (bit_idx == 4'd0) begin
                dac_cs_n <= 1'b1;
                state    <= GAP;
              end else begin
                // next bit goes out on the falling edge, so it is settled by the next rise
                bit_idx   <= bit_idx - 4'd1;
                shreg     <= {shreg[14:0], 1'b0};
                dac_sdata <= shreg[14];
              end
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        GAP: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            state <= IDLE;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a tick during a frame drops the sample; setting beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (tick && (state != IDLE)) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef DDS_MIX_CLIP_DETECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip <= 1'b0;
    end else if (tick && (state == IDLE) && sat_hit) begin
      clip <= 1'b1;
    end else if (ovr_clr) begin
      clip <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dds_mix_dac.sv
// Bench for dds_mix_dac: a default-rate instance plus an over-subscribed one (SAMPLE_DIV=100),
// both compared every cycle against a timing model, with directed frames and literal checks.
module tb_dds_mix_dac;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [63:0] ch = 64'h0;

  logic [15:0] so  [2];
  logic        sv  [2];
  logic        cs  [2];
  logic        sck [2];
  logic        sd  [2];
  logic        bz  [2];
  logic        ovr [2];
`ifdef DDS_MIX_CLIP_DETECT_EN
  logic        clp [2];
`endif

  always #5 clk = ~clk;

  dds_mix_dac #(.NCH(4), .CLKDIV(CD), .SAMPLE_DIV(256)) u_dut (
    .clk(clk), .reset_n(reset_n), .ch_samples(ch), .ovr_clr(ovr_clr),
    .sample_out(so[0]), .sample_valid(sv[0]), .dac_cs_n(cs[0]), .dac_sclk(sck[0]),
    .dac_sdata(sd[0]), .busy(bz[0]), .overrun(ovr[0])
`ifdef DDS_MIX_CLIP_DETECT_EN
    , .clip(clp[0])
`endif
  );

  dds_mix_dac #(.NCH(4), .CLKDIV(CD), .SAMPLE_DIV(100)) u_ovr (
    .clk(clk), .reset_n(reset_n), .ch_samples(ch), .ovr_clr(ovr_clr),
    .sample_out(so[1]), .sample_valid(sv[1]), .dac_cs_n(cs[1]), .dac_sclk(sck[1]),
    .dac_sdata(sd[1]), .busy(bz[1]), .overrun(ovr[1])
`ifdef DDS_MIX_CLIP_DETECT_EN
    , .clip(clp[1])
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s[%0d] t=%0t got=%h expected=%h", nm, i, $time, got, exp);
    end
  endtask

  function automatic int sd_of(input int i);
    return (i == 0) ? 256 : 100;
  endfunction

  function automatic int mix_sum(input logic [63:0] v);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'($signed(v[16*k +: 16]));
    return s;
  endfunction

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  int cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // Model: edges since release, frame start edge; outputs follow from elapsed time in the frame
  int          e_m  [2] = '{0, 0};
  int          fs_m [2] = '{-1, -1};
  logic [15:0] so_m [2] = '{16'h0, 16'h0};
  logic [15:0] wd_m [2] = '{16'h0, 16'h0};
  logic        v_m  [2] = '{1'b0, 1'b0};
  logic        ov_m [2] = '{1'b0, 1'b0};
  logic        cl_m [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        e_m[i] = 0; fs_m[i] = -1; so_m[i] = 16'h0; wd_m[i] = 16'h0;
        v_m[i] = 1'b0; ov_m[i] = 1'b0; cl_m[i] = 1'b0;
      end else begin
        bit tk, bsy;
        int s;
        e_m[i]++;
        v_m[i] = 1'b0;
        tk  = (e_m[i] % sd_of(i)) == 0;
        bsy = (fs_m[i] >= 0) && ((e_m[i] - 1 - fs_m[i]) < 33*CD);
        if (tk && bsy)   ov_m[i] = 1'b1;
        else if (ovr_clr) ov_m[i] = 1'b0;
        if (tk && !bsy) begin
          s = mix_sum(ch);
          so_m[i] = sat16(s);
          v_m[i]  = 1'b1;
          wd_m[i] = so_m[i] ^ 16'h8000;
          fs_m[i] = e_m[i];
          if (s > 32767 || s < -32768) cl_m[i] = 1'b1;
          else if (ovr_clr)            cl_m[i] = 1'b0;
        end else if (ovr_clr) begin
          cl_m[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      logic ecs, esck, ebz;
      d    = e_m[i] - fs_m[i];
      ebz  = (fs_m[i] >= 0) && (d < 33*CD);
      ecs  = !((fs_m[i] >= 0) && (d < 32*CD));
      esck = !ecs && ((d % (2*CD)) >= CD);
      chk("sample_out", i, so[i], so_m[i]);
      chk("sample_valid", i, 16'(sv[i]), 16'(v_m[i]));
      chk("busy", i, 16'(bz[i]), 16'(ebz));
      chk("overrun", i, 16'(ovr[i]), 16'(ov_m[i]));
      chk("dac_cs_n", i, 16'(cs[i]), 16'(ecs));
      chk("dac_sclk", i, 16'(sck[i]), 16'(esck));
      if (!ecs) chk("dac_sdata", i, 16'(sd[i]), 16'(wd_m[i][15 - d/(2*CD)]));
`ifdef DDS_MIX_CLIP_DETECT_EN
      chk("clip", i, 16'(clp[i]), 16'(cl_m[i]));
`endif
    end
  end

  // Frame capture on the default instance, sampled mid-cycle
  logic        p_sck = 1'b0, p_cs = 1'b1;
  logic [15:0] acc = 16'h0;
  int rises = 0, cslow = 0, frames = 0, rises_total = 0;
  int l_word = 0, l_rises = 0, l_cslow = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      acc = 16'h0; rises = 0; cslow = 0; rises_total = 0; p_sck = 1'b0; p_cs = 1'b1;
    end else begin
      if (sck[0] && !p_sck) begin
        acc = {acc[14:0], sd[0]};
        rises++;
        rises_total++;
      end
      if (!cs[0]) cslow++;
      if (cs[0] && !p_cs) begin
        l_word = acc; l_rises = rises; l_cslow = cslow; frames++;
        acc = 16'h0; rises = 0; cslow = 0;
      end
      p_sck = sck[0];
      p_cs  = cs[0];
    end
  end

  int last_tick_cyc = 0;

  // Random channel data every cycle except the default instance's tick cycle
  task automatic run_frame(input logic [63:0] v, input logic [15:0] eso, input logic [15:0] ewd);
    int g = 0;
    int f0;
    while (((cyc + 1) % 256) != 0 && g < 1000) begin
      ch = {$urandom, $urandom};
      @(negedge clk); #1;
      g++;
    end
    ch = v;
    f0 = frames;
    @(posedge clk); #1;
    last_tick_cyc = cyc;
    chk("tick_valid", 0, 16'(sv[0]), 16'h1);
    chk("tick_sample", 0, so[0], eso);
    chk("tick_phase", 0, 16'(cyc % 256), 16'h0);
    g = 0;
    while (frames == f0 && g < 400) begin
      ch = {$urandom, $urandom};
      @(negedge clk); #1;
      g++;
    end
    chk("frame_done", 0, 16'(frames - f0), 16'h1);
    chk("frame_word", 0, 16'(l_word), ewd);
    chk("frame_rises", 0, 16'(l_rises), 16'd16);
    chk("frame_cslow", 0, 16'(l_cslow), 16'd128);
  endtask

  task automatic idle_until(input int edge_no);
    int g = 0;
    while ((cyc + 1) != edge_no && g < 2000) begin
      ch = {$urandom, $urandom};
      @(negedge clk); #1;
      g++;
    end
    chk("idle_reach", 0, 16'(cyc + 1), 16'(edge_no));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, g;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sample_out", i, so[i], 16'h0);
      chk("rst_valid", i, 16'(sv[i]), 16'h0);
      chk("rst_cs_n", i, 16'(cs[i]), 16'h1);
      chk("rst_sclk", i, 16'(sck[i]), 16'h0);
      chk("rst_sdata", i, 16'(sd[i]), 16'h0);
      chk("rst_busy", i, 16'(bz[i]), 16'h0);
      chk("rst_overrun", i, 16'(ovr[i]), 16'h0);
    end
    reset_n = 1'b1;

    run_frame({4{16'h0100}}, 16'h0400, 16'h8400);
    chk("first_tick_cycle", 0, 16'(last_tick_cyc), 16'd256);

    // second instance: accepted at 100, dropped at 200 while its 132-cycle frame ran
    chk("ovr_after_200", 1, 16'(ovr[1]), 16'h1);
    chk("no_ovr_default", 0, 16'(ovr[0]), 16'h0);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_cleared", 1, 16'(ovr[1]), 16'h0);

    run_frame({16'h0000, 16'h0000, 16'h7000, 16'h7000}, 16'h7FFF, 16'hFFFF);
`ifdef DDS_MIX_CLIP_DETECT_EN
    chk("clip_set", 0, 16'(clp[0]), 16'h1);
`endif

    // edge 800 is a dropped tick on the second instance; set must beat clear
    idle_until(800);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_set_wins", 1, 16'(ovr[1]), 16'h1);

    run_frame({16'h0000, 16'hFFFF, 16'h8000, 16'h8000}, 16'h8000, 16'h0000);
    run_frame({16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'hFFFF, 16'h7FFF);
    run_frame({16'h0001, 16'hFF00, 16'h0010, 16'h1234}, 16'h1145, 16'h9145);

    // reset during bit 7 (69 cycles into the frame, sclk high)
    idle_until(1792);
    ch = {4{16'h2222}};
    g = 0;
    while (cyc != 1861 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("pre_rst_sclk", 0, 16'(sck[0]), 16'h1);
    chk("pre_rst_cs_n", 0, 16'(cs[0]), 16'h0);
    f0 = frames;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 0, 16'(cs[0]), 16'h1);
    chk("mid_rst_sclk", 0, 16'(sck[0]), 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    g = 0;
    while (cyc != 255 && g < 400) begin
      @(negedge clk);
      g++;
    end
    #1;
    chk("post_rst_rises", 0, 16'(rises_total), 16'h0);
    chk("post_rst_frames", 0, 16'(frames - f0), 16'h0);
    chk("post_rst_cs_n", 0, 16'(cs[0]), 16'h1);

    run_frame({16'h0400, 16'hFC00, 16'h0001, 16'h0002}, 16'h0003, 16'h8003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
